// File: rtl/alu_op_driver_if.sv
// Host-side command and response channels of the ALU operation driver.
// The master is the host controller; the slave is alu_op_driver.
interface alu_op_driver_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [3:0] cmd_opcode;
    logic       cmd_mode;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_seq;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_mode, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_seq
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_mode, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_seq
    );
endinterface

// File: rtl/alu_op_driver.sv
// Issues host commands to the fixed-latency ALU, tracks them through its pipeline
// and buffers each tagged result byte in an in-order response FIFO.
module alu_op_driver #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic           clk,
    input  logic           rst,
    alu_op_driver_if.slave bus,
    output logic [7:0]     alu_ab,
    output logic [7:0]     alu_ctrl,
    input  logic [7:0]     alu_result,
    output logic           busy,
    output logic [7:0]     err_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [4:0]       pipe_r [0:LATENCY];
    logic [11:0]      mem_r  [0:DEPTH-1];
    logic [3:0]       seq_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] fifo_cnt_r;
    logic [CNT_W-1:0] outst_r;
    logic [CNT_W-1:0] fifo_cnt_next_s;
    logic [CNT_W-1:0] outst_next_s;
    logic             ready_r;
    logic             rsp_valid_r;
    logic             busy_r;
    logic [7:0]       alu_ab_r;
    logic [7:0]       alu_ctrl_r;
    logic [7:0]       err_cnt_r;
    logic             accept_s;
    logic             pop_s;
    logic             push_s;
    logic [11:0]      head_s;

    assign bus.cmd_ready = ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_data  = head_s[11:4];
    assign bus.rsp_seq   = head_s[3:0];
    assign alu_ab        = alu_ab_r;
    assign alu_ctrl      = alu_ctrl_r;
    assign busy          = busy_r;
    assign err_count     = err_cnt_r;

    // Handshake qualification and next-state occupancy counts
    always_comb begin
        accept_s        = bus.cmd_valid && ready_r;
        pop_s           = rsp_valid_r && bus.rsp_ready;
        push_s          = pipe_r[LATENCY][4];
        head_s          = mem_r[rd_ptr_r];
        outst_next_s    = outst_r;
        fifo_cnt_next_s = fifo_cnt_r;
        if (accept_s && !pop_s) begin
            outst_next_s = outst_r + CNT_W'(1);
        end else if (!accept_s && pop_s) begin
            outst_next_s = outst_r - CNT_W'(1);
        end else begin
            outst_next_s = outst_r;
        end
        if (push_s && !pop_s) begin
            fifo_cnt_next_s = fifo_cnt_r + CNT_W'(1);
        end else if (!push_s && pop_s) begin
            fifo_cnt_next_s = fifo_cnt_r - CNT_W'(1);
        end else begin
            fifo_cnt_next_s = fifo_cnt_r;
        end
    end

    // Command issue, in-flight tracking, response FIFO and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= LATENCY; i++) begin
                pipe_r[i] <= 5'd0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 12'd0;
            end
            seq_r       <= 4'd0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            fifo_cnt_r  <= '0;
            outst_r     <= '0;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            alu_ab_r    <= 8'd0;
            alu_ctrl_r  <= 8'd0;
            err_cnt_r   <= 8'd0;
        end else begin
            if (accept_s) begin
                alu_ab_r   <= {bus.cmd_b, bus.cmd_a};
                alu_ctrl_r <= {3'b000, bus.cmd_mode, bus.cmd_opcode};
                seq_r      <= seq_r + 4'd1;
            end
            // Stage k holds the op issued k+1 edges ago; the last stage lines up with its result
            pipe_r[0] <= {accept_s, seq_r};
            for (int i = 1; i <= LATENCY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
            if (push_s) begin
                mem_r[wr_ptr_r] <= {alu_result, pipe_r[LATENCY][3:0]};
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                if (head_s[8] && (err_cnt_r != 8'hFF)) begin
                    err_cnt_r <= err_cnt_r + 8'd1;
                end
            end
            fifo_cnt_r  <= fifo_cnt_next_s;
            outst_r     <= outst_next_s;
            ready_r     <= (outst_next_s < DEPTH_C);
            rsp_valid_r <= (fifo_cnt_next_s != '0);
            busy_r      <= (outst_next_s != '0);
        end
    end
endmodule

// File: tb/tb_alu_op_driver.sv
// Directed bench for alu_op_driver with a two-stage behavioural ALU model.
module tb_alu_op_driver;
    logic       clk;
    logic       rst;
    logic [7:0] alu_ab;
    logic [7:0] alu_ctrl;
    logic [7:0] alu_result;
    logic       busy;
    logic [7:0] err_count;

    int errors;
    int checks;
    int acc_cnt;
    logic [11:0] pop_q [$];
    logic [7:0] m1_r;
    logic [7:0] m2_r;

    alu_op_driver_if bus ();

    alu_op_driver #(.LATENCY(2), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_ab(alu_ab), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .busy(busy), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU: op0 add, op3 divide (ALU) / max (NPU); flags {Z, C, S, E}
    function automatic logic [7:0] alu_f(input logic [7:0] ab, input logic [7:0] ctrl);
        logic [3:0] a, b, res;
        logic [4:0] sum;
        logic c, e;
        a = ab[3:0]; b = ab[7:4]; c = 1'b0; e = 1'b0;
        sum = {1'b0, a} + {1'b0, b};
        if (!ctrl[4]) begin
            case (ctrl[3:0])
                4'd0: begin res = sum[3:0]; c = sum[4]; end
                4'd3: begin
                    if (b == 4'd0) begin res = 4'd0; e = 1'b1; end
                    else res = a / b;
                end
                default: res = a ^ b;
            endcase
        end else begin
            case (ctrl[3:0])
                4'd3:    res = (a > b) ? a : b;
                default: res = a & b;
            endcase
        end
        return {(res == 4'd0), c, 1'b0, e, res};
    endfunction

    always @(posedge clk) begin
        m1_r <= alu_f(alu_ab, alu_ctrl);
        m2_r <= m1_r;
    end
    assign alu_result = m2_r;

    // Handshake monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.cmd_valid && bus.cmd_ready) acc_cnt <= acc_cnt + 1;
            if (bus.rsp_valid && bus.rsp_ready) pop_q.push_back({bus.rsp_seq, bus.rsp_data});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic mode, input logic [3:0] a, input logic [3:0] b);
        logic ok;
        int n;
        bus.cmd_opcode = op; bus.cmd_mode = mode; bus.cmd_a = a; bus.cmd_b = b;
        bus.cmd_valid = 1'b1;
        n = 0;
        do begin
            ok = bus.cmd_ready;
            tick();
            n++;
        end while (!ok && n < 50);
        bus.cmd_valid = 1'b0;
        check_eq("issue_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic pop_one();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.rsp_ready = 1'b1;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        bus.rsp_ready = 1'b0;
        check_eq("drain_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base, a0, p0, pstart, o, maxo, bad_seq, bad_dat, prate;
        logic [7:0] exp_d;
        errors = 0; checks = 0; acc_cnt = 0;
        bus.cmd_valid = 1'b0; bus.cmd_a = 4'd0; bus.cmd_b = 4'd0;
        bus.cmd_opcode = 4'd0; bus.cmd_mode = 1'b0; bus.rsp_ready = 1'b0;
        rst = 1'b1;
        tick(); tick();
        check_eq("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check_eq("rst_alu_ab", {24'd0, alu_ab}, 32'd0);
        check_eq("rst_alu_ctrl", {24'd0, alu_ctrl}, 32'd0);
        check_eq("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check_eq("rst_rsp_data", {24'd0, bus.rsp_data}, 32'd0);
        check_eq("rst_rsp_seq", {28'd0, bus.rsp_seq}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_err_count", {24'd0, err_count}, 32'd0);
        rst = 1'b0;

        // Single add: 3 + 5
        do_reset();
        issue(4'd0, 1'b0, 4'd3, 4'd5);
        check_eq("add_alu_ab", {24'd0, alu_ab}, 32'h53);
        check_eq("add_alu_ctrl", {24'd0, alu_ctrl}, 32'h00);
        wait_rsp(n);
        check_eq("add_latency", n, 32'd3);
        check_eq("add_rsp_data", {24'd0, bus.rsp_data}, 32'h08);
        check_eq("add_rsp_seq", {28'd0, bus.rsp_seq}, 32'd0);
        check_eq("add_busy", {31'd0, busy}, 32'd1);
        pop_one();
        check_eq("add_rsp_valid_after_pop", {31'd0, bus.rsp_valid}, 32'd0);
        check_eq("add_busy_after_pop", {31'd0, busy}, 32'd0);

        // Backpressure: four commands, no pops
        do_reset();
        for (int i = 0; i < 4; i++) issue(4'd0, 1'b0, 4'(i), 4'd1);
        check_eq("bp_ready_low", {31'd0, bus.cmd_ready}, 32'd0);
        bus.cmd_a = 4'd15; bus.cmd_b = 4'd15; bus.cmd_valid = 1'b1;
        repeat (6) tick();
        bus.cmd_valid = 1'b0;
        check_eq("bp_ready_stays_low", {31'd0, bus.cmd_ready}, 32'd0);
        check_eq("bp_alu_ab_held", {24'd0, alu_ab}, 32'h13);
        check_eq("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check_eq("bp_seq0", {28'd0, bus.rsp_seq}, 32'd0);
        check_eq("bp_data0", {24'd0, bus.rsp_data}, 32'h01);
        pop_one();
        check_eq("bp_ready_rise", {31'd0, bus.cmd_ready}, 32'd1);
        for (int i = 1; i < 4; i++) begin
            check_eq("bp_seq", {28'd0, bus.rsp_seq}, i);
            check_eq("bp_data", {24'd0, bus.rsp_data}, i + 1);
            pop_one();
        end
        check_eq("bp_busy_end", {31'd0, busy}, 32'd0);

        // Divide by zero and err_count saturation
        issue(4'd3, 1'b0, 4'd7, 4'd0);
        wait_rsp(n);
        check_eq("div_rsp_data", {24'd0, bus.rsp_data}, 32'h90);
        check_eq("div_err_before_pop", {24'd0, err_count}, 32'd0);
        pop_one();
        check_eq("div_err_after_pop", {24'd0, err_count}, 32'd1);
        base = pop_q.size();
        bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b1;
        n = 0;
        while ((pop_q.size() - base) < 260 && n < 3000) begin
            tick();
            n++;
        end
        bus.cmd_valid = 1'b0;
        drain();
        check_eq("div_stream_pops", {31'd0, (pop_q.size() - base) >= 260}, 32'd1);
        check_eq("div_err_saturated", {24'd0, err_count}, 32'd255);

        // Full FIFO, then pop and accept every cycle
        do_reset();
        a0 = acc_cnt; p0 = pop_q.size();
        bus.cmd_opcode = 4'd0; bus.cmd_mode = 1'b0; bus.cmd_a = 4'd5; bus.cmd_b = 4'd2;
        bus.cmd_valid = 1'b1;
        repeat (8) tick();
        check_eq("full_ready_low", {31'd0, bus.cmd_ready}, 32'd0);
        check_eq("full_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        bus.rsp_ready = 1'b1;
        maxo = 0; pstart = pop_q.size();
        repeat (40) begin
            tick();
            o = (acc_cnt - a0) - (pop_q.size() - p0);
            if (o > maxo) maxo = o;
        end
        prate = pop_q.size() - pstart;
        bus.cmd_valid = 1'b0;
        drain();
        bad_seq = 0; bad_dat = 0;
        for (int k = p0; k < pop_q.size(); k++) begin
            if (pop_q[k][11:8] != 4'((k - p0) % 16)) bad_seq++;
            if (pop_q[k][7:0] != 8'h07) bad_dat++;
        end
        check_eq("full_max_outstanding", {31'd0, maxo <= 4}, 32'd1);
        check_eq("full_no_loss", pop_q.size() - p0, acc_cnt - a0);
        check_eq("full_seq_order", bad_seq, 32'd0);
        check_eq("full_data", bad_dat, 32'd0);
        check_eq("full_rate", {31'd0, prate >= 30}, 32'd1);

        // Sequence wrap over 17 commands
        do_reset();
        p0 = pop_q.size();
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 16; k++) issue(4'd0, 1'b0, 4'(k), 4'd0);
        issue(4'd3, 1'b1, 4'd9, 4'd4);
        check_eq("wrap_alu_ctrl", {24'd0, alu_ctrl}, 32'h13);
        check_eq("wrap_alu_ab", {24'd0, alu_ab}, 32'h49);
        drain();
        check_eq("wrap_count", pop_q.size() - p0, 32'd17);
        if (pop_q.size() - p0 >= 17) begin
            for (int k = 0; k < 17; k++) begin
                if (k == 0) exp_d = 8'h80;
                else if (k < 16) exp_d = 8'(k);
                else exp_d = 8'h09;
                check_eq("wrap_seq", {28'd0, pop_q[p0 + k][11:8]}, k % 16);
                check_eq("wrap_data", {24'd0, pop_q[p0 + k][7:0]}, {24'd0, exp_d});
            end
        end

        // Reset with two in flight and one buffered
        do_reset();
        issue(4'd0, 1'b0, 4'd1, 4'd1);
        issue(4'd0, 1'b0, 4'd2, 4'd1);
        issue(4'd0, 1'b0, 4'd3, 4'd1);
        tick();
        check_eq("mid_rsp_valid_pre", {31'd0, bus.rsp_valid}, 32'd1);
        check_eq("mid_busy_pre", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check_eq("mid_busy", {31'd0, busy}, 32'd0);
        repeat (5) begin
            tick();
            check_eq("mid_rsp_valid_quiet", {31'd0, bus.rsp_valid}, 32'd0);
        end
        check_eq("mid_busy_quiet", {31'd0, busy}, 32'd0);
        issue(4'd0, 1'b0, 4'd2, 4'd2);
        wait_rsp(n);
        check_eq("mid_next_latency", n, 32'd3);
        check_eq("mid_next_seq", {28'd0, bus.rsp_seq}, 32'd0);
        check_eq("mid_next_data", {24'd0, bus.rsp_data}, 32'h04);
        pop_one();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alu_op_driver.md
# alu_op_driver

Command-side initiator for the custom ALU/NPU tile. Accepts operation requests on a valid/ready command port and drives the ALU's operand and control pins. It tracks each issued operation through the ALU's fixed two-register pipeline and captures the 8-bit status/result byte into a response FIFO, tagged with a sequence number. It sits between a host controller and the ALU, letting the host issue one operation per cycle without counting pipeline stages.

## Interface
- LATENCY, 2: clock edges from an `alu_ab`/`alu_ctrl` update to `alu_result` reflecting it; supported range 1–7.
- DEPTH, 4: response FIFO entries; also the cap on outstanding operations; power of two, 2–8.

- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command can be accepted
- cmd_a  in  4  operand A
- cmd_b  in  4  operand B
- cmd_opcode  in  4  opcode
- cmd_mode  in  1  0 = ALU mode, 1 = NPU mode
- alu_ab  out  8  {B, A} to the ALU operand pins
- alu_ctrl  out  8  {3'b000, mode, opcode} to the ALU control pins
- alu_result  in  8  {Zero, Carry, Sign, Error, Result[3:0]} from the ALU
- rsp_valid  out  1  response at FIFO head
- rsp_ready  in  1  host consumes the response
- rsp_data  out  8  captured `alu_result`
- rsp_seq  out  4  sequence tag of the response
- busy  out  1  any operation in flight or buffered
- err_count  out  8  saturating count of popped responses with `rsp_data[4]` (Error) set

## Operation
- **Accept.** A command is accepted when `cmd_valid && cmd_ready` is true at a rising edge.
  - At that edge, `alu_ab <= {cmd_b, cmd_a}` and `alu_ctrl <= {3'b0, cmd_mode, cmd_opcode}`.
  - `seq` increments.
- **Idle cycles.** With no accept, `alu_ab` and `alu_ctrl` hold their values. Results produced by held values are never captured.
- **In-flight tracking.** A shift register of LATENCY+1 stages, each holding `{valid, seq[3:0]}`.
  - Stage 0 loads `{accept, seq}` every edge.
  - When the last stage is valid, `alu_result` is sampled at that edge and pushed into the FIFO as `{alu_result, seq}`.
- **FIFO.** DEPTH entries, in order.
  - `rsp_valid` = FIFO not empty. `rsp_data` and `rsp_seq` show the head entry.
  - Pop on `rsp_valid && rsp_ready`. The head must be stable while `rsp_valid && !rsp_ready`.
- **Credit.**
  - outstanding = valid in-flight stages + FIFO count.
  - `cmd_ready = (outstanding < DEPTH)`. It is a function of registered state only, with no path from `cmd_valid` or `rsp_ready`.
  - The FIFO can therefore never overflow. A push is never dropped.
- **Sequence counter.** 4-bit `seq` starts at 0 and wraps 15→0.
- **busy** = outstanding != 0.
- **err_count.** Increments on a pop whose `rsp_data[4]` = 1. It saturates at 255.
- **Simultaneous push and pop.** FIFO count is unchanged; order is preserved.
- **Pop while full and accept in the same cycle.** The accept is allowed only if `cmd_ready` was already high. `cmd_ready` rises in the cycle after the pop.
- **Reset.** All state clears. In-flight operations are discarded, and the results they later produce from the ALU are ignored.

## Timing
- Reset values: `cmd_ready` = 1, `alu_ab` = 0, `alu_ctrl` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_seq` = 0, `busy` = 0, `err_count` = 0.
- Accept at edge T:
  - `alu_*` change after T.
  - `alu_result` reflects the operation after edge T+LATENCY.
  - Capture happens at edge T+LATENCY+1.
  - `rsp_valid` is high after edge T+LATENCY+1 (3 cycles with the default) if the FIFO was empty.
- Throughput: one command per cycle while `outstanding < DEPTH` and the host pops every cycle.
- `cmd_ready` falls in the cycle after the accept that brings outstanding to DEPTH.

## Test plan
- **Single add.** After reset, issue A=3, B=5, op=0000, mode=0, with a behavioural ALU model (LATENCY=2).
  - Expect `rsp_data` = 0x08 and `rsp_seq` = 0.
  - `rsp_valid` rises exactly 3 cycles after accept.
  - `busy` returns to 0 after the pop.
- **Backpressure.** Issue 4 back-to-back commands with `rsp_ready` = 0.
  - `cmd_ready` = 0 after the 4th accept and stays low.
  - Raise `rsp_ready` for 1 cycle: `cmd_ready` = 1 the next cycle.
  - Responses arrive in order with seq 0, 1, 2, 3.
- **Divide by zero.** Issue op=0011, A=7, B=0, mode=0.
  - Expect `rsp_data` = 0x90 (Zero and Error set).
  - `err_count` goes 0→1 on the pop, not before.
  - Force 260 such pops: `err_count` holds at 255.
- **Full with simultaneous pop and accept.** FIFO full, `rsp_ready` = 1 every cycle, `cmd_valid` = 1.
  - Steady state: one response per cycle, outstanding never exceeds 4, no lost or duplicated seq.
- **Sequence wrap.** Issue 17 commands.
  - `rsp_seq` runs 0..15 then 0.
  - The 17th response carries the data of the 17th command (NPU op=0011, A=9, B=4 → `rsp_data` = 0x09).
- **Reset mid-operation.** Assert `rst` for 1 cycle with 2 operations in flight and 1 buffered.
  - Afterwards: `rsp_valid` stays 0 for 5 cycles, `cmd_ready` = 1, `busy` = 0.
  - The next command returns `rsp_seq` = 0.
